// File: rtl/seq_mult_datapath.sv
// -----------------------------------------------------------------------------
// seq_mult_datapath
//
// Purpose:
//   Standalone WIDTHxWIDTH unsigned sequential multiplier. A multiply takes four
//   steps. Each step forms one (WIDTH/2)x(WIDTH/2) partial product from a pair
//   of operand halves. That partial product is shifted into place and added to
//   a 2*WIDTH accumulator. A start/busy/done handshake controls the unit.
//
// Ports:
//   clk       in   1        rising-edge clock
//   aclr_n    in   1        asynchronous active-low reset
//   start     in   1        request; only sampled while idle
//   dataa     in   WIDTH    multiplicand, captured when start is accepted
//   datab     in   WIDTH    multiplier, captured when start is accepted
//   abort     in   1        (only with SEQ_MULT_ABORT_EN) cancel a running multiply
//   busy      out  1        high while a multiply is in progress
//   done      out  1        one-cycle pulse when product is updated
//   product   out  2*WIDTH  result; holds until the next completion
//   step_out  out  2        current step count (0 while idle)
//
// Configuration:
//   SEQ_MULT_ABORT_EN - when defined, adds the abort input. abort cancels a
//   running multiply. It wins over a completion on the same edge, and it has
//   no effect while idle.
// -----------------------------------------------------------------------------
module seq_mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dataa,
  input  logic [WIDTH-1:0]     datab,
`ifdef SEQ_MULT_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           step_out
);

  localparam int H = WIDTH / 2;

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [1:0]           step_reg;

  logic [H-1:0]         op_a;
  logic [H-1:0]         op_b;
  logic [WIDTH-1:0]     pp;
  logic [2*WIDTH-1:0]   term;

  // Operand-half selection and alignment for the current step.
  always_comb begin
    op_a = a_reg[H-1:0];
    op_b = b_reg[H-1:0];
    case (step_reg)
      2'd1:    begin op_a = a_reg[WIDTH-1:H]; op_b = b_reg[H-1:0];     end
      2'd2:    begin op_a = a_reg[H-1:0];     op_b = b_reg[WIDTH-1:H]; end
      2'd3:    begin op_a = a_reg[WIDTH-1:H]; op_b = b_reg[WIDTH-1:H]; end
      default: begin op_a = a_reg[H-1:0];     op_b = b_reg[H-1:0];     end
    endcase
  end

  assign pp = WIDTH'(op_a) * WIDTH'(op_b);

  always_comb begin
    term = {{WIDTH{1'b0}}, pp};
    case (step_reg)
      2'd1, 2'd2: term = {{WIDTH{1'b0}}, pp} << H;
      2'd3:       term = {{WIDTH{1'b0}}, pp} << WIDTH;
      default:    term = {{WIDTH{1'b0}}, pp};
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      step_reg  <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      product   <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= dataa;
            b_reg     <= datab;
            acc_reg   <= '0;
            step_reg  <= 2'd0;
            busy      <= 1'b1;
            state_reg <= CALC;
          end
        end
        CALC: begin
`ifdef SEQ_MULT_ABORT_EN
          if (abort) begin
            acc_reg   <= '0;
            step_reg  <= 2'd0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else
`endif
          if (step_reg == 2'd3) begin
            // Fold the last term directly into the product and drop back to idle.
            product   <= acc_reg + term;
            done      <= 1'b1;
            busy      <= 1'b0;
            step_reg  <= 2'd0;
            state_reg <= IDLE;
          end else begin
            acc_reg  <= acc_reg + term;
            step_reg <= step_reg + 2'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign step_out = step_reg;

endmodule

// File: tb/tb_seq_mult_datapath.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_datapath
//
// Purpose:
//   Directed self-checking bench for seq_mult_datapath (WIDTH=8). It covers the
//   reset state, plain multiplies, a back-to-back start in the done cycle, a
//   start while busy, an asynchronous clear in mid-operation and, with
//   SEQ_MULT_ABORT_EN, the abort path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_mult_datapath;

  logic        clk = 1'b0;
  logic        aclr_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  dataa = 8'h00;
  logic [7:0]  datab = 8'h00;
`ifdef SEQ_MULT_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [1:0]  step_out;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_mult_datapath #(.WIDTH(8)) dut (
    .clk      (clk),
    .aclr_n   (aclr_n),
    .start    (start),
    .dataa    (dataa),
    .datab    (datab),
`ifdef SEQ_MULT_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .product  (product),
    .step_out (step_out)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // Advance one clock edge and settle 1ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outputs(input string tag, input logic b, input logic d,
                         input logic [15:0] p, input logic [1:0] s);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".product"}, 32'(product), 32'(p));
    check({tag, ".step"}, 32'(step_out), 32'(s));
    $display("%0t %s busy=%0b done=%0b product=0x%04h step=%0d",
             $time, tag, busy, done, product, step_out);
  endtask

  initial begin
    // 1. reset state
    #12;
    aclr_n = 1'b1;
    tick(); tick(); tick();
    outputs("reset", 1'b0, 1'b0, 16'h0000, 2'd0);

    // 2. 0x12 * 0x34
    dataa = 8'h12; datab = 8'h34; start = 1'b1;
    tick();
    start = 1'b0; dataa = 8'hEE; datab = 8'hEE;   // late changes must not matter
    outputs("m1.e0", 1'b1, 1'b0, 16'h0000, 2'd0);
    tick(); outputs("m1.e1", 1'b1, 1'b0, 16'h0000, 2'd1);
    tick(); outputs("m1.e2", 1'b1, 1'b0, 16'h0000, 2'd2);
    tick(); outputs("m1.e3", 1'b1, 1'b0, 16'h0000, 2'd3);
    tick(); outputs("m1.e4", 1'b0, 1'b1, 16'h03A8, 2'd0);
    tick(); outputs("m1.after", 1'b0, 1'b0, 16'h03A8, 2'd0);

    // 3. 0xFF * 0xFF, then 0x00 * 0xAB started in the done cycle
    dataa = 8'hFF; datab = 8'hFF; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    outputs("m2.done", 1'b0, 1'b1, 16'hFE01, 2'd0);
    dataa = 8'h00; datab = 8'hAB; start = 1'b1;
    tick(); start = 1'b0;
    outputs("m3.e0", 1'b1, 1'b0, 16'hFE01, 2'd0);
    tick(); tick(); tick(); tick();
    outputs("m3.done", 1'b0, 1'b1, 16'h0000, 2'd0);

    // 4. start while busy is ignored
    dataa = 8'h0F; datab = 8'h10; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    check("m4.step2", 32'(step_out), 32'd2);
    dataa = 8'h02; datab = 8'h03; start = 1'b1;
    tick(); start = 1'b0;
    outputs("m4.e3", 1'b1, 1'b0, 16'h0000, 2'd3);
    tick(); outputs("m4.done", 1'b0, 1'b1, 16'h00F0, 2'd0);
    tick(); outputs("m4.nodone1", 1'b0, 1'b0, 16'h00F0, 2'd0);
    tick(); outputs("m4.nodone2", 1'b0, 1'b0, 16'h00F0, 2'd0);

    // 5. asynchronous clear mid-operation
    dataa = 8'hAA; datab = 8'h55; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("m5.step1", 32'(step_out), 32'd1);
    #2 aclr_n = 1'b0;
    #1 outputs("m5.clr", 1'b0, 1'b0, 16'h0000, 2'd0);
    tick();
    aclr_n = 1'b1;
    tick(); tick(); tick(); tick();
    outputs("m5.quiet", 1'b0, 1'b0, 16'h0000, 2'd0);
    dataa = 8'h03; datab = 8'h05; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    outputs("m5.done", 1'b0, 1'b1, 16'h000F, 2'd0);

`ifdef SEQ_MULT_ABORT_EN
    // 6. abort at step 3 beats completion
    tick();
    dataa = 8'h20; datab = 8'h20; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    check("m6.step3", 32'(step_out), 32'd3);
    abort = 1'b1;
    tick(); abort = 1'b0;
    outputs("m6.abort", 1'b0, 1'b0, 16'h000F, 2'd0);
    tick(); outputs("m6.after", 1'b0, 1'b0, 16'h000F, 2'd0);
    // abort coinciding with start in idle is ignored
    dataa = 8'h20; datab = 8'h20; start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    outputs("m7.e0", 1'b1, 1'b0, 16'h000F, 2'd0);
    tick(); tick(); tick(); tick();
    outputs("m7.done", 1'b0, 1'b1, 16'h0400, 2'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
